instr_mem_loader: RTL

Parametrised, loadable instruction memory for the single-cycle/multicycle core.
- After reset it sequentially clears the array, then enters RUN.
- In RUN it serves byte-addressed fetches with one-cycle registered latency and accepts program words over a valid/ready load port.
- It flags misaligned and out-of-range fetches to the control unit.

---
 rtl/instr_mem_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Loadable instruction memory: clears on reset, optional boot program
// (PRELOAD_PROGRAM_EN), then serves registered fetches and accepts loads.
module instr_mem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              out_of_range,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic              ready
);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_PRELOAD = 2'd1,
    S_RUN     = 2'd2,
    S_BAD     = 2'd3
  } state_t;

  state_t r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_instr;
  logic r_vld;
  logic r_mis;
  logic r_oor;

  logic w_run;
  logic w_we;
  logic [IDX_W-1:0] w_widx;
  logic [DATA_W-1:0] w_wdata;
  logic [IDX_W-1:0] w_fidx;
  logic w_mis;
  logic w_oor;

  assign w_run = (r_state == S_RUN);
  assign ready = w_run;
  assign load_ready = w_run;

  assign w_fidx = fetch_addr[IDX_W+1:2];
  assign w_mis = |fetch_addr[1:0];
  assign w_oor = (fetch_addr >> (IDX_W + 2)) != '0;

`ifdef PRELOAD_PROGRAM_EN
  localparam int BOOT_N = 12;

  // Step 11 of the boot sequence lands on the branch target at word 20.
  function automatic logic [31:0] boot_word(input logic [3:0] k);
    case (k)
      4'd0:    boot_word = 32'h0022_1824;
      4'd1:    boot_word = 32'h0022_2025;
      4'd2:    boot_word = 32'h0022_2826;
      4'd3:    boot_word = 32'h0022_3027;
      4'd4:    boot_word = 32'h0022_3820;
      4'd5:    boot_word = 32'h0022_4022;
      4'd6:    boot_word = 32'h0022_482A;
      4'd7:    boot_word = 32'h0041_502A;
      4'd8:    boot_word = 32'h8C0B_0004;
      4'd9:    boot_word = 32'hAC0B_0004;
      4'd10:   boot_word = 32'h0800_0005;
      4'd11:   boot_word = 32'h1003_FFEB;
      default: boot_word = 32'h0;
    endcase
  endfunction

  logic [IDX_W-1:0] w_pre_idx;
  assign w_pre_idx = (r_idx[3:0] == 4'd11) ? IDX_W'(20) : r_idx;
`endif

  always_comb begin
    w_we = 1'b0;
    w_widx = r_idx;
    w_wdata = '0;
    case (r_state)
      S_CLEAR: w_we = 1'b1;
`ifdef PRELOAD_PROGRAM_EN
      S_PRELOAD: begin
        w_we = 1'b1;
        w_widx = w_pre_idx;
        w_wdata = DATA_W'(boot_word(r_idx[3:0]));
      end
`endif
      S_RUN: begin
        w_we = load_valid;
        w_widx = load_idx;
        w_wdata = load_data;
      end
      default: w_we = 1'b0;
    endcase
  end

  // Array is deliberately not reset; CLEAR scrubs it instead.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(DEPTH - 1)) begin
`ifdef PRELOAD_PROGRAM_EN
            r_state <= S_PRELOAD;
`else
            r_state <= S_RUN;
`endif
          end
        end
`ifdef PRELOAD_PROGRAM_EN
        S_PRELOAD: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(BOOT_N - 1)) begin
            r_state <= S_RUN;
            r_idx <= '0;
          end
        end
`endif
        S_RUN: r_state <= S_RUN;
        default: begin
          r_state <= S_CLEAR;
          r_idx <= '0;
        end
      endcase
    end
  end

  // Read uses pre-edge contents, so a same-cycle load is seen next fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
      r_vld <= 1'b0;
      r_mis <= 1'b0;
      r_oor <= 1'b0;
    end else if (w_run && fetch_en) begin
      r_instr <= w_oor ? '0 : r_mem[w_fidx];
      r_vld <= 1'b1;
      r_mis <= w_mis;
      r_oor <= w_oor;
    end else begin
      r_vld <= 1'b0;
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_vld;
  assign misaligned = r_mis;
  assign out_of_range = r_oor;

endmodule
